// File: rtl/soc_mmio.sv
// soc_mmio -- memory-mapped RAM and peripheral block behind the core's mem_* port.
//
// Contents: byte-maskable on-chip RAM, an active-low LED register, and a
// free-running 32-bit counter with compare-match flag driving irq.
// All reads are registered with one-cycle latency.
//
// Parameters:
//   RAM_WORDS  RAM depth in 32-bit words (power of two, >= 2)
//   LED_W      LED register width (1..32)
//   IO_BIT     address bit selecting the IO page when set
//
// Ports:
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   mem_addr    byte address, bits [1:0] ignored
//   mem_wdata   write data
//   mem_wmask   byte write enables, any bit set = write cycle
//   mem_rstrb   read strobe
//   mem_rdata   registered read data
//   mem_rvalid  one-cycle pulse one cycle after an accepted strobe
//   LED         board LEDs, active-low
//   irq         compare-match flag
//
// Build option: define SOC_MMIO_BIG_ENDIAN_EN to byte-swap data and reverse
// the write mask on the RAM path. IO registers are never swapped.

module soc_mmio #(
    parameter int RAM_WORDS = 1024,
    parameter int LED_W     = 8,
    parameter int IO_BIT    = 22
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    input  logic             mem_rstrb,
    output logic [31:0]      mem_rdata,
    output logic             mem_rvalid,
    output logic [LED_W-1:0] LED,
    output logic             irq
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [2:0] REG_LED    = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_CMP    = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    logic [31:0]      ram_q [RAM_WORDS];
    logic [LED_W-1:0] led_q;
    logic [31:0]      count_q, cmp_q;
    logic             flag_q, flag_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;

    logic             io_sel, wr_en, io_wr, ram_wr;
    logic [AW-1:0]    ram_idx;
    logic [2:0]       reg_sel;
    logic [31:0]      ram_wdata, ram_rdata, io_rdata;
    logic [3:0]       ram_mask;

    // Only a subset of address bits is decoded; the rest alias by design.
    logic unused_addr;
    assign unused_addr = ^mem_addr;

    assign io_sel  = mem_addr[IO_BIT];
    assign wr_en   = |mem_wmask;
    assign io_wr   = wr_en & io_sel;
    assign ram_wr  = wr_en & ~io_sel;
    assign ram_idx = mem_addr[2 +: AW];
    assign reg_sel = mem_addr[4:2];

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

`ifdef SOC_MMIO_BIG_ENDIAN_EN
    assign ram_wdata = bswap(mem_wdata);
    assign ram_mask  = {mem_wmask[0], mem_wmask[1], mem_wmask[2], mem_wmask[3]};
    assign ram_rdata = bswap(ram_q[ram_idx]);
`else
    assign ram_wdata = mem_wdata;
    assign ram_mask  = mem_wmask;
    assign ram_rdata = ram_q[ram_idx];
`endif

    // RAM is not reset; read path samples the pre-write word, giving
    // read-before-write on a same-cycle access.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_mask[i]) ram_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        io_rdata = 32'h0;
        case (reg_sel)
            REG_LED:    io_rdata = 32'(led_q);
            REG_COUNT:  io_rdata = count_q;
            REG_CMP:    io_rdata = cmp_q;
            REG_STATUS: io_rdata = {31'h0, flag_q};
            default:    io_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (mem_rstrb) rdata_d = io_sel ? io_rdata : ram_rdata;
    end

    // Set has priority over W1C so a match coinciding with a clear is not lost.
    always_comb begin
        flag_d = flag_q;
        if (io_wr && reg_sel == REG_STATUS && mem_wdata[0]) flag_d = 1'b0;
        if (count_q == cmp_q) flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q    <= '0;
            count_q  <= 32'h0;
            cmp_q    <= 32'hFFFF_FFFF;
            flag_q   <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
        end else begin
            count_q  <= count_q + 32'd1;
            flag_q   <= flag_d;
            rdata_q  <= rdata_d;
            rvalid_q <= mem_rstrb;
            if (io_wr && reg_sel == REG_LED) led_q <= mem_wdata[LED_W-1:0];
            if (io_wr && reg_sel == REG_CMP) cmp_q <= mem_wdata;
        end
    end

    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;
    assign LED        = ~led_q;
    assign irq        = flag_q;

endmodule

// File: doc/soc_mmio.md
# soc_mmio

Memory-mapped memory and peripheral subsystem between the `refemv` core's memory port and the board. It generalises the fixed RAM, endian-converter and LED hookup into one parametrised block. It contains byte-maskable on-chip RAM, an active-low LED register and a 32-bit cycle counter with compare-match interrupt, all behind the core's `mem_*` signals. All reads are registered with one-cycle latency. Byte-lane order on the RAM path is selectable at compile time.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words. Must be a power of two, ≥ 2.
- `LED_W`, 8: LED register width, 1–32.
- `IO_BIT`, 22: address bit that selects the IO page when set.

- `clk`  in  1  system clock, all state on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `mem_addr`  in  32  byte address from core; bits [1:0] ignored
- `mem_wdata`  in  32  write data
- `mem_wmask`  in  4  byte write enables; any bit set = write cycle
- `mem_rstrb`  in  1  read strobe, one cycle per read
- `mem_rdata`  out  32  registered read data
- `mem_rvalid`  out  1  high exactly one cycle after an accepted `mem_rstrb`
- `LED`  out  LED_W  board LEDs, active-low (`~led_reg`)
- `irq`  out  1  compare-match flag

## Operation
- Decode: `mem_addr[IO_BIT]`=0 selects RAM; =1 selects IO.
- RAM index = `mem_addr[2 +: log2(RAM_WORDS)]`. Upper address bits are ignored, so the RAM aliases (wraps) every RAM_WORDS*4 bytes.
- RAM write: each byte lane i with `mem_wmask[i]`=1 is written; other lanes are preserved.
- IO registers are selected by `mem_addr[4:2]`:
  - 0 LED: RW, `led_reg[LED_W-1:0]`; upper read bits are 0.
  - 1 COUNT: RO, free-running 32-bit counter. Increments every cycle and wraps 0xFFFFFFFF→0. Writes are ignored.
  - 2 CMP: RW, 32-bit compare value.
  - 3 STATUS: bit0 = match flag. Writing 1 to bit0 clears it; writing 0 has no effect. Bits [31:1] read 0.
  - 4–7: read 0, writes ignored.
- IO writes are full-word. `mem_wmask` acts only as a write enable (any bit set) on IO registers.
- Match: on every cycle where COUNT == CMP, the flag is set at the next edge. `irq` = flag.
- Simultaneous write and read to the same RAM word: `mem_rdata` returns the old data (read-before-write).
- Simultaneous W1C and match: set wins, flag stays 1.
- CPU write to CMP: takes effect at the next edge. A match is evaluated against the registered CMP.
- Read strobe and write in the same cycle are both honoured.

## Timing
- Read latency is 1 cycle. `mem_rstrb` at edge N gives `mem_rdata` valid and `mem_rvalid`=1 after edge N+1.
- `mem_rdata` holds its value until the next accepted read. `mem_rvalid` deasserts when there is no new strobe.
- COUNT read returns the value sampled at the strobe edge.
- Writes complete at the edge they are presented on. There is no stall and no back-pressure.
- Reset values, applied asynchronously on `rstn`=0:
  - `mem_rdata`=0, `mem_rvalid`=0
  - `led_reg`=0, so `LED`=all ones
  - COUNT=0, CMP=0xFFFFFFFF, flag=0, `irq`=0
- RAM contents are not reset.
- Reset asserted mid-read: `mem_rvalid` is forced to 0 and the pending read is discarded.
- After release, COUNT increments from the first edge with `rstn`=1.

## Configuration
- `SOC_MMIO_BIG_ENDIAN_EN` defined: the RAM path byte-swaps.
  - Lanes are swapped `[7:0]↔[31:24]` and `[15:8]↔[23:16]` on `mem_wdata` and `mem_rdata`.
  - `mem_wmask` is bit-reversed (bit0↔bit3, bit1↔bit2) before the RAM.
  - IO registers are never swapped.
- Not defined: the RAM path is little-endian pass-through, and the mask is applied as given.

## Test plan
- Reset check:
  - Hold `rstn`=0 mid-sequence → `LED`=0xFF, `irq`=0, `mem_rvalid`=0.
  - Read CMP after release → 0xFFFFFFFF.
- RAM byte mask (macro off):
  - Write 0x11223344 mask 0xF to 0x10, then 0xAABBCCDD mask 0x2 → read 0x10 returns 0x1122CC44 with `mem_rvalid` one cycle after strobe.
  - Read 0x10 + RAM_WORDS*4 → same value (wrap).
- Read-before-write:
  - Same-cycle write 0x55 and strobe on a word holding 0 → `mem_rdata`=0.
  - Next read → 0x55.
- LED: write 0x000000A5 to IO offset 0 → `LED`=0x5A; read back 0x000000A5.
- Compare-match:
  - Set CMP = COUNT+20 → `irq` rises exactly one cycle after COUNT==CMP.
  - W1C on the same cycle as a second match → `irq` stays 1.
  - Plain W1C → `irq`=0 next cycle.
- Endian build (macro on): write 0x11223344 mask 0x1 → a non-swapped view of the RAM word shows byte 0x44 in lane 3; CPU readback returns 0x00000044.
